fifo_wr_arbiter: RTL and testbench



---
 rtl/fifo_wr_arbiter_pkg.sv | 12 +
 rtl/fifo_wr_arbiter_rr_pick.sv | 29 ++
 rtl/fifo_wr_arbiter.sv | 105 ++++++++++
 tb/tb_fifo_wr_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared definitions for the FIFO write-side arbiter: FSM encodings and debug
// counter width.
package fifo_arb_defs;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_t;

  localparam int CNT_W = 32;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin selector: first set bit of req at or after ptr,
// searching upward and wrapping (N_REQ is a power of two).
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   ptr,
  output logic             any,
  output logic [IDW-1:0]   idx
);

  logic [IDW-1:0] cand;

  // Walk offsets from far to near so the closest requester wins.
  always_comb begin
    any  = 1'b0;
    idx  = '0;
    cand = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = ptr + IDW'(k);
      if (req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ producers, with
// bounded bursts, full back-pressure and debug word/stall counters.
module fifo_wr_arbiter
  import fifo_arb_defs::*;
#(
  parameter int WIDTH     = 16,
  parameter int N_REQ     = 4,
  parameter int MAX_BURST = 8,
  localparam int IDW      = $clog2(N_REQ)
) (
  input  logic                   wr_clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  input  logic [N_REQ-1:0]       req_last,
  output logic [N_REQ-1:0]       req_ready,
  input  logic                   fifo_full,
  output logic                   wr_en,
  output logic [WIDTH-1:0]       wr_data,
  output logic [IDW-1:0]         grant_id,
  output logic                   busy,
  output logic [CNT_W-1:0]       word_cnt,
  output logic [CNT_W-1:0]       stall_cnt,
  output logic [IDW-1:0]         rr_ptr
);

  localparam int BCW = $clog2(MAX_BURST) + 1;
  localparam logic [BCW-1:0] BURST_LAST = BCW'(MAX_BURST - 1);

  arb_state_t       state, state_nxt;
  logic [BCW-1:0]   burst_cnt;
  logic             pick_any;
  logic [IDW-1:0]   pick_idx;
  logic             g_valid, g_last;
  logic [WIDTH-1:0] g_data;
  logic             xfer, stall, burst_end;

  rr_pick #(.N_REQ(N_REQ), .IDW(IDW)) u_pick (
    .req (req_valid),
    .ptr (rr_ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  always_comb begin
    g_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_id == IDW'(i)) g_data = req_data[i*WIDTH +: WIDTH];
    end
  end

  assign g_valid = req_valid[grant_id];
  assign g_last  = req_last[grant_id];
  assign busy    = (state == ST_BURST);

  // Handshake: a word of requester i moves when req_valid[i] & req_ready[i];
  // only the granted requester sees ready, and ready drops whenever the FIFO is
  // full, so that single condition is exactly wr_en.
  assign xfer      = busy & g_valid & ~fifo_full & ~rst;
  assign stall     = busy & g_valid & fifo_full;
  assign burst_end = busy & (~g_valid | (xfer & (g_last | (burst_cnt == BURST_LAST))));

  always_comb begin
    req_ready = '0;
    if (busy && !rst) req_ready[grant_id] = ~fifo_full;
  end

  assign wr_en   = xfer;
  assign wr_data = busy ? g_data : '0;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (pick_any)  state_nxt = ST_BURST;
      ST_BURST: if (burst_end) state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge wr_clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge wr_clk) begin
    if (rst) begin
      grant_id  <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
      word_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      if (!busy && pick_any) begin
        grant_id  <= pick_idx;
        burst_cnt <= '0;
      end
      if (xfer) begin
        burst_cnt <= burst_cnt + BCW'(1);
        word_cnt  <= word_cnt + CNT_W'(1);
      end
      if (stall)     stall_cnt <= stall_cnt + CNT_W'(1);
      if (burst_end) rr_ptr    <= grant_id + IDW'(1);
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus random traffic, with a
// per-cycle reference model and a per-requester word-order scoreboard.
module tb_fifo_wr_arbiter;

  localparam int WIDTH     = 16;
  localparam int N_REQ     = 4;
  localparam int MAX_BURST = 8;
  localparam int IDW       = 2;

  logic                   wr_clk;
  logic                   rst;
  logic [N_REQ-1:0]       req_valid, req_last, req_ready;
  logic [N_REQ*WIDTH-1:0] req_data;
  logic                   fifo_full, wr_en, busy;
  logic [WIDTH-1:0]       wr_data;
  logic [IDW-1:0]         grant_id, rr_ptr;
  logic [31:0]            word_cnt, stall_cnt;

  fifo_wr_arbiter #(.WIDTH(WIDTH), .N_REQ(N_REQ), .MAX_BURST(MAX_BURST)) dut (
    .wr_clk    (wr_clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .fifo_full (fifo_full),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .grant_id  (grant_id),
    .busy      (busy),
    .word_cnt  (word_cnt),
    .stall_cnt (stall_cnt),
    .rr_ptr    (rr_ptr)
  );

  // ---------------- clock ----------------
  initial wr_clk = 1'b0;
  always #5 wr_clk = ~wr_clk;

  // ---------------- shared state ----------------
  int n_checks = 0;
  int n_fail   = 0;

  logic [WIDTH-1:0] exp_q[N_REQ][$];
  logic [WIDTH-1:0] src_d[N_REQ][$];
  bit               src_l[N_REQ][$];
  int               seq[N_REQ];
  bit               gate[N_REQ];
  logic [N_REQ-1:0] acc = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Word tag: requester id in the top 4 bits, per-requester sequence below.
  task automatic push_word(input int i, input bit last);
    logic [WIDTH-1:0] w;
    w = {4'(i), 12'(seq[i])};
    seq[i]++;
    src_d[i].push_back(w);
    src_l[i].push_back(last);
    exp_q[i].push_back(w);
  endtask

  task automatic drive();
    for (int i = 0; i < N_REQ; i++) begin
      if (src_d[i].size() > 0 && gate[i]) begin
        req_valid[i]                = 1'b1;
        req_data[i*WIDTH +: WIDTH]  = src_d[i][0];
        req_last[i]                 = src_l[i][0];
      end else begin
        req_valid[i]                = 1'b0;
        req_data[i*WIDTH +: WIDTH]  = WIDTH'($urandom);
        req_last[i]                 = 1'($urandom_range(0, 1));
      end
    end
  endtask

  task automatic tick();
    @(posedge wr_clk);
    #1;
    for (int i = 0; i < N_REQ; i++) begin
      if (acc[i]) begin
        void'(src_d[i].pop_front());
        void'(src_l[i].pop_front());
      end
    end
    drive();
  endtask

  // ---------------- reference model ----------------
  bit               model_on = 1'b0;
  bit               m_busy   = 1'b0;
  int               m_owner  = 0;
  int               m_ptr    = 0;
  int               m_cnt    = 0;
  logic [31:0]      m_words  = '0;
  logic [31:0]      m_stalls = '0;
  logic [N_REQ-1:0] e_ready;
  logic             e_wr;
  bit               found;

  always @(negedge wr_clk) begin
    acc     = req_valid & req_ready;
    e_ready = '0;
    e_wr    = 1'b0;
    if (m_busy && !rst) begin
      e_ready[m_owner] = !fifo_full;
      e_wr             = req_valid[m_owner] && !fifo_full;
    end
    if (model_on) begin
      check("busy", busy, m_busy);
      check("wr_en", wr_en, e_wr);
      check("req_ready", req_ready, e_ready);
      check("word_cnt", word_cnt, m_words);
      check("stall_cnt", stall_cnt, m_stalls);
      check("rr_ptr", rr_ptr, m_ptr);
      if (m_busy) check("grant_id", grant_id, m_owner);
      if (e_wr)   check("wr_data_owner", wr_data[WIDTH-1 -: 4], m_owner);
      if (!m_busy) check("wr_data_idle", wr_data, 0);
    end
    if (rst) begin
      m_busy = 0; m_owner = 0; m_ptr = 0; m_cnt = 0;
      m_words = '0; m_stalls = '0; model_on = 1'b1;
    end else if (!m_busy) begin
      found = 1'b0;
      for (int k = 0; k < N_REQ; k++) begin
        if (!found && req_valid[(m_ptr + k) % N_REQ]) begin
          found   = 1'b1;
          m_owner = (m_ptr + k) % N_REQ;
        end
      end
      if (found) begin
        m_busy = 1'b1;
        m_cnt  = 0;
      end
    end else if (e_wr) begin
      m_words = m_words + 1;
      m_cnt++;
      if (req_last[m_owner] || m_cnt == MAX_BURST) begin
        m_busy = 1'b0;
        m_ptr  = (m_owner + 1) % N_REQ;
      end
    end else if (req_valid[m_owner]) begin
      m_stalls = m_stalls + 1;
    end else begin
      m_busy = 1'b0;
      m_ptr  = (m_owner + 1) % N_REQ;
    end
  end

  // ---------------- scoreboard monitor ----------------
  int               sb_id;
  int               sb_pend;
  logic [WIDTH-1:0] sb_exp;
  logic [31:0]      sb_words = '0;

  always @(negedge wr_clk) begin
    if (rst) begin
      sb_words = '0;
    end else if (wr_en) begin
      check("no_wr_when_full", fifo_full, 0);
      sb_id   = int'(wr_data[WIDTH-1 -: 4]);
      sb_pend = (sb_id < N_REQ) ? exp_q[sb_id].size() : 0;
      if (sb_pend > 0) begin
        sb_exp = exp_q[sb_id].pop_front();
        check("sb_order", wr_data, sb_exp);
      end else begin
        check("sb_pending_word", sb_pend, 1);
      end
      sb_words = sb_words + 1;
    end
  end

  // ---------------- stimulus ----------------
  int nw;
  int prev_busy;
  int pending;
  int gq[$];
  int wcnt[N_REQ];

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; fifo_full = 1'b0;
    req_valid = '0; req_data = '0; req_last = '0;
    for (int i = 0; i < N_REQ; i++) begin gate[i] = 0; seq[i] = 0; end
    do_reset();
    @(negedge wr_clk);
    check("rst_busy", busy, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_ready", req_ready, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_word_cnt", word_cnt, 0);
    check("rst_stall_cnt", stall_cnt, 0);
    check("rst_rr_ptr", rr_ptr, 0);

    // Single requester, three-word burst ending on last.
    push_word(1, 0); push_word(1, 0); push_word(1, 1);
    gate[1] = 1;
    tick(); @(negedge wr_clk);
    check("t1_idle_cycle", busy, 0);
    nw = 0;
    for (int c = 0; c < 8; c++) begin
      tick(); @(negedge wr_clk);
      if (c == 0) begin
        check("t1_grant", grant_id, 1);
        check("t1_busy", busy, 1);
      end
      if (wr_en) nw++;
    end
    check("t1_writes", nw, 3);
    check("t1_word_cnt", word_cnt, 3);
    check("t1_rr_ptr", rr_ptr, 2);
    check("t1_back_idle", busy, 0);

    // All requesters continuously valid, never last.
    for (int i = 0; i < N_REQ; i++) gate[i] = 0;
    do_reset();
    for (int i = 0; i < N_REQ; i++) begin
      repeat (40) push_word(i, 0);
      gate[i] = 1;
      wcnt[i] = 0;
    end
    tick(); @(negedge wr_clk);
    prev_busy = 0;
    for (int c = 1; c <= 36; c++) begin
      tick(); @(negedge wr_clk);
      if (busy && !prev_busy) gq.push_back(int'(grant_id));
      if (wr_en) wcnt[grant_id]++;
      prev_busy = busy;
      if (c == 36) begin
        check("t2_word_cnt", word_cnt, 32);
        check("t2_bubble", busy, 0);
      end
    end
    check("t2_bursts", gq.size(), 4);
    for (int k = 0; k < N_REQ; k++) begin
      check("t2_grant_order", (k < gq.size()) ? gq[k] : 99, k);
      check("t2_burst_len", wcnt[k], 8);
    end
    for (int i = 0; i < N_REQ; i++) gate[i] = 0;
    repeat (3) tick();

    // FIFO full for five cycles in the middle of requester 2's burst.
    gate[2] = 1;
    tick(); @(negedge wr_clk);
    nw = 0;
    for (int c = 0; c < 16; c++) begin
      tick();
      fifo_full = (c >= 3 && c < 8);
      @(negedge wr_clk);
      if (fifo_full) begin
        check("t3_full_wr_en", wr_en, 0);
        check("t3_full_ready", req_ready[2], 0);
        check("t3_full_busy", busy, 1);
        check("t3_full_grant", grant_id, 2);
      end
      if (wr_en) nw++;
      if (nw == 8) gate[2] = 0;
    end
    check("t3_writes", nw, 8);
    check("t3_stall_cnt", stall_cnt, 5);
    check("t3_rr_ptr", rr_ptr, 3);
    check("t3_idle", busy, 0);

    // Requesters 0 and 3 contend with rr_ptr at 3; a gap ends 3's burst.
    gate[0] = 1; gate[3] = 1;
    tick(); @(negedge wr_clk);
    check("t4_idle", busy, 0);
    tick(); @(negedge wr_clk);
    check("t4_grant_first", grant_id, 3);
    check("t4_write1", wr_en, 1);
    tick(); @(negedge wr_clk);
    check("t4_write2", wr_en, 1);
    gate[3] = 0;
    tick(); @(negedge wr_clk);
    check("t4_gap_busy", busy, 1);
    check("t4_gap_no_write", wr_en, 0);
    gate[3] = 1;
    tick(); @(negedge wr_clk);
    check("t4_bubble", busy, 0);
    check("t4_rr_ptr", rr_ptr, 0);
    tick(); @(negedge wr_clk);
    check("t4_grant_second", grant_id, 0);
    check("t4_busy_second", busy, 1);

    // Reset in the middle of requester 0's burst.
    tick(); @(negedge wr_clk);
    check("t5_pre_write", wr_en, 1);
    tick();
    rst = 1'b1;
    @(negedge wr_clk);
    check("t5_rst_wr_en", wr_en, 0);
    check("t5_rst_ready", req_ready, 0);
    tick();
    rst = 1'b0;
    @(negedge wr_clk);
    check("t5_busy", busy, 0);
    check("t5_word_cnt", word_cnt, 0);
    check("t5_stall_cnt", stall_cnt, 0);
    check("t5_rr_ptr", rr_ptr, 0);

    // Random valid / last / full traffic.
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < N_REQ; i++) begin
        gate[i] = ($urandom_range(0, 3) != 0);
        if (src_d[i].size() < 6 && $urandom_range(0, 1) == 1)
          push_word(i, $urandom_range(0, 4) == 0);
      end
      tick();
      fifo_full = ($urandom_range(0, 4) == 0);
    end

    // Drain everything still held by the producers.
    fifo_full = 1'b0;
    for (int i = 0; i < N_REQ; i++) gate[i] = 1;
    pending = 0;
    for (int i = 0; i < N_REQ; i++) pending += src_d[i].size();
    for (int c = 0; c < 2000 && pending > 0; c++) begin
      tick();
      pending = 0;
      for (int i = 0; i < N_REQ; i++) pending += src_d[i].size();
    end
    check("drain_done", pending, 0);
    repeat (3) tick();
    @(negedge wr_clk);
    for (int i = 0; i < N_REQ; i++) check("sb_leftover", exp_q[i].size(), 0);
    check("word_cnt_vs_sb", word_cnt, sb_words);
    check("final_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
